uart_tx: RTL
============

# uart_tx

Serial UART transmitter, the transmit counterpart of the board's `uart_top` receive path. It accepts a byte over a valid/ready handshake and shifts it out on a single line as 8N1 frames, LSB first, at a fixed clocks-per-bit rate. It sits between user logic and the FPGA TX pin on the Spartan-6 board.

## Interface
- `CLKS_PER_BIT`, default 1250: clock cycles per serial bit. Must be ≥ 2.
- `STOP_BITS`, default 1: number of stop bits, either 1 or 2.
- `clk`, input, 1: system clock. All logic is on the rising edge.
- `rst`, input, 1: reset, asynchronous, active-low.
- `tx`, input, 8: byte to transmit. Sampled only on handshake acceptance.
- `tx_valid`, input, 1: `tx` holds a byte to send.
- `tx_ready`, output, 1: high when the block can accept a byte.
- `tx_data`, output, 1: serial line. Idles high.
- `tx_done`, output, 1: one-cycle pulse at the end of each frame.

## Operation
- The FSM states are IDLE, START, DATA, PARITY (present only with the macro), and STOP.
- **IDLE**
  - `tx_ready` = 1 and `tx_data` = 1.
  - When `tx_valid` && `tx_ready`, latch `tx` into the shift register, clear the bit index, and go to START.
- **START:** `tx_data` = 0 for `CLKS_PER_BIT` cycles, then go to DATA.
- **DATA**
  - `tx_data` = `shift[0]` for `CLKS_PER_BIT` cycles per bit, then shift right.
  - The 3-bit index counts 0..7. After bit 7, go to PARITY if enabled, otherwise STOP.
- **STOP:** `tx_data` = 1 for `STOP_BITS`×`CLKS_PER_BIT` cycles, then go to IDLE.
- The baud counter is sized `$clog2(CLKS_PER_BIT)`. It counts 0..`CLKS_PER_BIT`-1 and wraps to 0 on every bit boundary. It is held at 0 in IDLE.
- `tx_valid` is ignored whenever `tx_ready` = 0. Changes to `tx` mid-frame have no effect.
- `tx_data` is driven directly from a register, so the line carries no glitches.

## Timing
- Reset values (asynchronous, while `rst` = 0):
  - `tx_data` = 1, `tx_ready` = 1, `tx_done` = 0.
  - State = IDLE and all counters = 0.
- Reset asserted mid-frame: the line returns high immediately and the frame is discarded. No `tx_done` is produced.
- Acceptance happens in cycle T.
  - In T+1: `tx_ready` = 0, `tx_data` = 0 (start bit).
  - Latency from handshake to the start edge is 1 cycle.
- Frame length is N×`CLKS_PER_BIT` cycles, where N = 1 + 8 + `STOP_BITS` (+1 with parity).
- `tx_done` = 1 only in the last cycle of the final stop bit.
- `tx_ready` returns to 1 in the cycle after `tx_done`.
- Back-to-back: `tx_valid` held high gives a start edge every N×`CLKS_PER_BIT`+1 cycles, with no extra idle bit.

## Configuration
- The macro is `UART_TX_PARITY_EN`.
- **Defined:** a PARITY state is inserted between DATA and STOP.
  - It drives even parity (XOR of the 8 data bits) for `CLKS_PER_BIT` cycles.
  - N grows by 1.
- **Undefined:** the PARITY state and its logic are absent, and frames are pure 8N1 / 8N2.

## Structure
- Shared package `uart_pkg` holds:
  - the state typedef (IDLE/START/DATA/PARITY/STOP);
  - `UART_DATA_BITS` = 8;
  - the default `CLKS_PER_BIT` constant, so it can be reused by the RX side.
- One sub-module, `uart_baud_tick`: a parameterised counter with `clear` input and `tick` output, where `tick` is high on count `CLKS_PER_BIT`-1.
- The FSM, shift register and bit index stay in `uart_tx`.

## Test plan
The bench uses `CLKS_PER_BIT` = 1250 with a 2 ns clock (2500 ns per bit).

- **Reset:** hold `rst` = 0 for 100 ns. Check `tx_data` = 1, `tx_ready` = 1, `tx_done` = 0. Check the line stays high for 5000 ns with `tx_valid` = 0.
- **Single byte:** send `tx` = 8'h41.
  - Sample at mid-bit every 2500 ns. The line must read 0,1,0,0,0,0,0,1,0,1.
  - `tx_done` pulses once at 25000 ns after the start edge.
- **Back-to-back:** hold `tx_valid` high with 8'h41 then 8'hA5.
  - The second start edge must be exactly 12501 cycles after the first.
  - The second frame must read 0,1,0,1,0,0,1,0,1,1.
- **Busy and data stability:** pulse `tx_valid` with 8'hFF mid-frame, and change `tx` mid-frame. Neither may alter the frame in progress, and no extra frame may be sent.
- **Reset mid-frame:** assert `rst` during bit 3 of 8'h00. The line goes high within the same cycle, no `tx_done` pulse occurs, and `tx_ready` = 1 after release.
- **Parity (`UART_TX_PARITY_EN`):** check the parity bit 8'h41 → 0 and 8'h07 → 1. `tx_done` occurs at 27500 ns.

Source files
------------

// File: rtl/uart_pkg.sv
`timescale 1ns / 1ps
// uart_pkg: shared UART types and constants for the TX and RX paths.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

    localparam int UART_DATA_BITS    = 8;
    localparam int UART_CLKS_PER_BIT = 1250;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } uart_state_t;

endpackage

// File: rtl/uart_baud_tick.sv
`timescale 1ns / 1ps
// uart_baud_tick: bit-period counter; tick marks the last clock of each bit.
// Held at zero while clear is high so every frame starts on a fresh bit.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;

    // NOTE: sequential state is only ever updated with non-blocking assignments
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (clear || tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign tick = !clear && (cnt_q == LAST);

endmodule

// File: rtl/uart_tx.sv
`timescale 1ns / 1ps
// uart_tx: valid/ready byte in, LSB-first 8N1/8N2 frames out on tx_data.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bits.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int STOP_BITS    = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [UART_DATA_BITS-1:0] tx,
    input  logic                      tx_valid,
    output logic                      tx_ready,
    output logic                      tx_data,
    output logic                      tx_done
);

    localparam int IDX_W = $clog2(UART_DATA_BITS);
    localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(UART_DATA_BITS - 1);
    localparam logic LAST_STOP = 1'(STOP_BITS - 1);

    uart_state_t               state_q, state_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]          bit_idx_q, bit_idx_d;
    logic                      stop_idx_q, stop_idx_d;
    logic                      line_q, line_d;
    logic                      done;
    logic                      bit_tick;
    logic                      baud_clear;
`ifdef UART_TX_PARITY_EN
    logic                      parity_q, parity_d;
`endif

    assign baud_clear = (state_q == IDLE);

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .rst  (rst),
        .clear(baud_clear),
        .tick (bit_tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            line_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            line_q     <= line_d;
`ifdef UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    // The line register is loaded with the level of the *next* cycle, so each
    // transition below also sets the bit that the new state will present.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path infers a latch
        state_d    = state_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        line_d     = line_q;
        done       = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d   = parity_q;
`endif

        case (state_q)
            IDLE: begin
                line_d = 1'b1;
                if (tx_valid) begin
                    shift_d    = tx;
                    bit_idx_d  = '0;
                    stop_idx_d = 1'b0;
                    line_d     = 1'b0;
                    state_d    = START;
`ifdef UART_TX_PARITY_EN
                    parity_d   = ^tx;
`endif
                end
            end

            START: begin
                if (bit_tick) begin
                    state_d = DATA;
                    line_d  = shift_q[0];
                end
            end

            DATA: begin
                if (bit_tick) begin
                    shift_d = {1'b0, shift_q[UART_DATA_BITS-1:1]};
                    if (bit_idx_q == LAST_BIT) begin
                        bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d   = PARITY;
                        line_d    = parity_q;
`else
                        state_d   = STOP;
                        line_d    = 1'b1;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                        line_d    = shift_q[1];
                    end
                end
            end

`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_tick) begin
                    state_d = STOP;
                    line_d  = 1'b1;
                end
            end
`endif

            STOP: begin
                line_d = 1'b1;
                if (bit_tick) begin
                    if (stop_idx_q == LAST_STOP) begin
                        state_d = IDLE;
                        done    = 1'b1;
                    end else begin
                        stop_idx_d = stop_idx_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                line_d  = 1'b1;
            end
        endcase
    end

    assign tx_ready = (state_q == IDLE);
    assign tx_data  = line_q;
    assign tx_done  = done;

endmodule
